// File: rtl/zeroriscy_fetch_fifo.sv
// rtl/zeroriscy_fetch_fifo.sv - word fetcher with request FSM, outstanding tracking and prefetch FIFO
module zeroriscy_fetch_fifo #(
  parameter int FIFO_DEPTH = 3,
  parameter int MAX_OTSD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [2:0] DEPTH_C    = 3'(FIFO_DEPTH);
  localparam logic [1:0] MAX_OTSD_C = 2'(MAX_OTSD);
  localparam logic [1:0] PTR_LAST   = 2'(FIFO_DEPTH - 1);
  localparam logic       AQ_LAST    = 1'(MAX_OTSD - 1);

  state_t      state;
  logic [31:0] fetch_addr;
  logic        stale;
  logic [1:0]  otsd_cnt;
  logic [1:0]  discard_cnt;
  logic [2:0]  fifo_cnt;
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [31:0] fifo_data [4];
  logic [31:0] fifo_addr [4];
  logic [31:0] aq [2];
  logic        aq_rd;
  logic        aq_wr;

  logic        gnt;
  logic        rv;
  logic        push;
  logic        pop;
  logic        credit;
  logic [1:0]  otsd_nxt;
  logic [2:0]  fifo_nxt;
  logic [31:0] fetch_addr_nxt;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic aq_inc(input logic p);
    return (p == AQ_LAST) ? 1'b0 : ~p;
  endfunction

  assign valid_o = (fifo_cnt != 3'd0);
  assign rdata_o = fifo_data[rd_ptr];
  assign addr_o  = fifo_addr[rd_ptr];
  assign busy_o  = instr_req_o | (otsd_cnt != 2'd0);

  always_comb begin
    gnt      = instr_req_o & instr_gnt_i;
    rv       = instr_rvalid_i & (otsd_cnt != 2'd0);
    push     = rv & ~branch_i & (discard_cnt == 2'd0);
    pop      = valid_o & ready_i & ~branch_i;
    otsd_nxt = otsd_cnt + 2'(gnt) - 2'(rv);
    fifo_nxt = branch_i ? 3'd0 : fifo_cnt + 3'(push) - 3'(pop);
    credit   = (({1'b0, otsd_nxt} + fifo_nxt) < DEPTH_C) && (otsd_nxt < MAX_OTSD_C);
    // A request that was in flight when a branch hit (stale) must not advance the new stream
    if (branch_i)
      fetch_addr_nxt = {addr_i[31:2], 2'b00};
    else if (gnt && !stale)
      fetch_addr_nxt = fetch_addr + 32'd4;
    else
      fetch_addr_nxt = fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_req_o  <= 1'b0;
      instr_addr_o <= 32'd0;
      fetch_addr   <= 32'd0;
      stale        <= 1'b0;
      otsd_cnt     <= 2'd0;
      discard_cnt  <= 2'd0;
      fifo_cnt     <= 3'd0;
      rd_ptr       <= 2'd0;
      wr_ptr       <= 2'd0;
      aq_rd        <= 1'b0;
      aq_wr        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= 32'd0;
        fifo_addr[i] <= 32'd0;
      end
      aq[0] <= 32'd0;
      aq[1] <= 32'd0;
    end else begin
      otsd_cnt   <= otsd_nxt;
      fifo_cnt   <= fifo_nxt;
      fetch_addr <= fetch_addr_nxt;

      if (gnt)
        stale <= 1'b0;
      else if (branch_i && state == REQ)
        stale <= 1'b1;

      // Everything still owed by memory belongs to the old stream, including a held request
      if (branch_i)
        discard_cnt <= otsd_cnt - 2'(rv) + 2'(state == REQ);
      else if (rv && discard_cnt != 2'd0)
        discard_cnt <= discard_cnt - 2'd1;

      case (state)
        IDLE: begin
          if (req_i && credit) begin
            state        <= REQ;
            instr_req_o  <= 1'b1;
            instr_addr_o <= fetch_addr_nxt;
          end
        end
        REQ: begin
          if (instr_gnt_i) begin
            if (req_i && credit) begin
              instr_addr_o <= fetch_addr_nxt;
            end else begin
              state       <= IDLE;
              instr_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase

      if (gnt) begin
        aq[aq_wr] <= instr_addr_o;
        aq_wr     <= aq_inc(aq_wr);
      end
      if (rv)
        aq_rd <= aq_inc(aq_rd);

      if (branch_i) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= instr_rdata_i;
          fifo_addr[wr_ptr] <= aq[aq_rd];
          wr_ptr            <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(instr_rvalid_i && otsd_cnt == 2'd0));
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && fifo_cnt == DEPTH_C));

endmodule
